// File: rtl/ex_operand_issue.sv
// ID/EX issue stage: decodes an RV32I subset into ALU operands and sideband,
// with a main register feeding the ALU and a skid register absorbing one stalled bundle.
module ex_operand_issue #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_rs1_data,
   input  logic [XLEN-1:0] in_rs2_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_in1,
   output logic [XLEN-1:0] out_in2,
   output logic [3:0]      out_alu_control,
   output logic [4:0]      out_rd,
   output logic            out_reg_write,
   output logic            out_is_branch,
   output logic            out_illegal
);

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0100;
   localparam logic [3:0] ALU_SLT = 4'b1000;

   typedef struct packed {
      logic [XLEN-1:0] in1;
      logic [XLEN-1:0] in2;
      logic [3:0]      alu;
      logic [4:0]      rd;
      logic            reg_write;
      logic            is_branch;
      logic            illegal;
   } bundle_t;

   // Handshake: a bundle moves upstream->stage when in_valid && in_ready, and
   // stage->ALU when out_valid && out_ready; in_ready depends only on held state.

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [4:0]      rd_field;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_s;
   logic            unused_rs1_field;

   assign opcode   = in_instr[6:0];
   assign funct3   = in_instr[14:12];
   assign funct7   = in_instr[31:25];
   assign rd_field = in_instr[11:7];
   assign imm_i    = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
   assign imm_s    = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign unused_rs1_field = ^in_instr[19:15];

   logic            legal;
   logic [3:0]      alu_sel;
   logic [XLEN-1:0] op2;
   logic            writes_rd;
   logic            branch;
   bundle_t         dec;

   always_comb begin
      legal     = 1'b0;
      alu_sel   = ALU_ADD;
      op2       = in_rs2_data;
      writes_rd = 1'b0;
      branch    = 1'b0;
      case (opcode)
         7'b0110011: begin
            writes_rd = 1'b1;
            if (funct7 == 7'b0000000) begin
               legal = 1'b1;
               case (funct3)
                  3'b000:  alu_sel = ALU_ADD;
                  3'b111:  alu_sel = ALU_AND;
                  3'b110:  alu_sel = ALU_OR;
                  3'b010:  alu_sel = ALU_SLT;
                  default: legal   = 1'b0;
               endcase
            end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
               legal   = 1'b1;
               alu_sel = ALU_SUB;
            end
         end
         7'b0010011: begin
            writes_rd = 1'b1;
            op2       = imm_i;
            legal     = 1'b1;
            case (funct3)
               3'b000:  alu_sel = ALU_ADD;
               3'b111:  alu_sel = ALU_AND;
               3'b110:  alu_sel = ALU_OR;
               3'b010:  alu_sel = ALU_SLT;
               default: legal   = 1'b0;
            endcase
         end
         7'b0000011: begin
            writes_rd = 1'b1;
            op2       = imm_i;
            legal     = (funct3 == 3'b010);
         end
         7'b0100011: begin
            op2   = imm_s;
            legal = (funct3 == 3'b010);
         end
         7'b1100011: begin
            alu_sel = ALU_SUB;
            branch  = 1'b1;
            legal   = (funct3 == 3'b000);
         end
         default: legal = 1'b0;
      endcase

      // Illegal words still issue as a zeroed ADD so the EX stage can trap on them.
      dec = '0;
      if (legal) begin
         dec.in1       = in_rs1_data;
         dec.in2       = op2;
         dec.alu       = alu_sel;
         dec.rd        = writes_rd ? rd_field : 5'd0;
         dec.reg_write = writes_rd && (rd_field != 5'd0);
         dec.is_branch = branch;
      end else begin
         dec.alu     = ALU_ADD;
         dec.illegal = 1'b1;
      end
   end

   bundle_t m_q;
   bundle_t s_q;
   logic    m_valid;
   logic    s_valid;
   logic    accept;

   assign in_ready = !s_valid;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q     <= '0;
         s_q     <= '0;
         m_valid <= 1'b0;
         s_valid <= 1'b0;
      end else if (flush) begin
         m_valid <= 1'b0;
         s_valid <= 1'b0;
      end else if (!m_valid || out_ready) begin
         // Skid entry is always older than the incoming bundle, so it drains first.
         if (s_valid) begin
            m_q     <= s_q;
            m_valid <= 1'b1;
         end else if (accept) begin
            m_q     <= dec;
            m_valid <= 1'b1;
         end else begin
            m_valid <= 1'b0;
         end
         s_valid <= 1'b0;
      end else if (accept) begin
         s_q     <= dec;
         s_valid <= 1'b1;
      end
   end

   assign out_valid       = m_valid;
   assign out_in1         = m_q.in1;
   assign out_in2         = m_q.in2;
   assign out_alu_control = m_q.alu;
   assign out_rd          = m_q.rd;
   assign out_reg_write   = m_q.reg_write;
   assign out_is_branch   = m_q.is_branch;
   assign out_illegal     = m_q.illegal;

endmodule

// File: tb/tb_ex_operand_issue.sv
// Bench for ex_operand_issue: directed decode table, hand-written handshake corner cases,
// then randomized traffic against a FIFO-level reference model.
module tb_ex_operand_issue;

   localparam int PW = 76;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_rs1_data;
   logic [31:0] in_rs2_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_in1;
   logic [31:0] out_in2;
   logic [3:0]  out_alu_control;
   logic [4:0]  out_rd;
   logic        out_reg_write;
   logic        out_is_branch;
   logic        out_illegal;
   logic [PW-1:0] dut_pay;

   ex_operand_issue #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_in1(out_in1), .out_in2(out_in2), .out_alu_control(out_alu_control),
      .out_rd(out_rd), .out_reg_write(out_reg_write),
      .out_is_branch(out_is_branch), .out_illegal(out_illegal)
   );

   assign dut_pay = {out_in1, out_in2, out_alu_control, out_rd,
                     out_reg_write, out_is_branch, out_illegal};

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;
   logic [PW-1:0] exp_q[$];

   task automatic chk_pay(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_bit(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   function automatic logic [PW-1:0] pk(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] alu, input logic [4:0] rd,
                                        input logic rw, input logic br, input logic il);
      return {a, b, alu, rd, rw, br, il};
   endfunction

   function automatic int f3_op(input logic [2:0] f3);
      case (f3)
         3'd0:    return 2;
         3'd7:    return 0;
         3'd6:    return 1;
         3'd2:    return 8;
         default: return -1;
      endcase
   endfunction

   // Reference decoder: classifies the word, then builds the bundle from the class.
   function automatic logic [PW-1:0] ref_decode(input logic [31:0] w, input logic [31:0] r1,
                                                input logic [31:0] r2);
      int          op  = -1;
      logic [31:0] b   = r2;
      logic        wr  = 1'b0;
      logic        br  = 1'b0;
      logic [6:0]  opc = w[6:0];
      logic [2:0]  f3  = w[14:12];
      logic [6:0]  f7  = w[31:25];
      logic [31:0] ii  = {{20{w[31]}}, w[31:20]};
      logic [31:0] is  = {{20{w[31]}}, w[31:25], w[11:7]};
      logic [4:0]  rd;
      if (opc == 7'h33) begin
         wr = 1'b1;
         if (f7 == 7'h00) op = f3_op(f3);
         else if (f7 == 7'h20 && f3 == 3'd0) op = 4;
      end else if (opc == 7'h13) begin
         wr = 1'b1; b = ii; op = f3_op(f3);
      end else if (opc == 7'h03 && f3 == 3'd2) begin
         wr = 1'b1; b = ii; op = 2;
      end else if (opc == 7'h23 && f3 == 3'd2) begin
         b = is; op = 2;
      end else if (opc == 7'h63 && f3 == 3'd0) begin
         br = 1'b1; op = 4;
      end
      if (op < 0) return pk(32'd0, 32'd0, 4'b0010, 5'd0, 1'b0, 1'b0, 1'b1);
      rd = wr ? w[11:7] : 5'd0;
      return pk(r1, b, op[3:0], rd, wr && (rd != 5'd0), br, 1'b0);
   endfunction

   typedef struct {
      string         name;
      logic [31:0]   instr;
      logic [31:0]   rs1;
      logic [31:0]   rs2;
      logic [PW-1:0] exp;
   } vec_t;
   vec_t vecs[$];

   function automatic vec_t mk(input string nm, input logic [31:0] w, input logic [31:0] r1,
                               input logic [31:0] r2, input logic [PW-1:0] e);
      vec_t v;
      v.name = nm; v.instr = w; v.rs1 = r1; v.rs2 = r2; v.exp = e;
      return v;
   endfunction

   task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] r1,
                        input logic [31:0] r2);
      in_valid = v; in_instr = w; in_rs1_data = r1; in_rs2_data = r2;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0] opc;
      logic [6:0] f7;
      case ($urandom_range(0, 6))
         0: opc = 7'h33;
         1: opc = 7'h13;
         2: opc = 7'h03;
         3: opc = 7'h23;
         4: opc = 7'h63;
         5: opc = 7'($urandom);
         default: return $urandom;
      endcase
      case ($urandom_range(0, 2))
         0: f7 = 7'h00;
         1: f7 = 7'h20;
         default: f7 = 7'($urandom);
      endcase
      return {f7, 5'($urandom), 5'($urandom), 3'($urandom_range(0, 7)), 5'($urandom), opc};
   endfunction

   logic [PW-1:0] pa, pb, pc;
   bit            acc, xfer;

   initial begin
      vecs.push_back(mk("add",      32'h002081B3, 32'd23,     32'd42,     pk(32'd23, 32'd42, 4'b0010, 5'd3, 1, 0, 0)));
      vecs.push_back(mk("sub",      32'h40208133, 32'd42,     32'd23,     pk(32'd42, 32'd23, 4'b0100, 5'd2, 1, 0, 0)));
      vecs.push_back(mk("beq",      32'h00208463, 32'd5,      32'd5,      pk(32'd5, 32'd5, 4'b0100, 5'd0, 0, 1, 0)));
      vecs.push_back(mk("addi_m1",  32'hFFF00293, 32'd0,      32'd7,      pk(32'd0, 32'hFFFFFFFF, 4'b0010, 5'd5, 1, 0, 0)));
      vecs.push_back(mk("nop",      32'h00000013, 32'd9,      32'd9,      pk(32'd9, 32'd0, 4'b0010, 5'd0, 0, 0, 0)));
      vecs.push_back(mk("ill_zero", 32'h00000000, 32'd1,      32'd2,      pk(32'd0, 32'd0, 4'b0010, 5'd0, 0, 0, 1)));
      vecs.push_back(mk("and",      32'h0020F233, 32'hF0F0,   32'h0FF0,   pk(32'hF0F0, 32'h0FF0, 4'b0000, 5'd4, 1, 0, 0)));
      vecs.push_back(mk("or",       32'h0020E333, 32'h1,      32'h2,      pk(32'h1, 32'h2, 4'b0001, 5'd6, 1, 0, 0)));
      vecs.push_back(mk("slt",      32'h0020A3B3, 32'hFFFFFFFF, 32'd1,    pk(32'hFFFFFFFF, 32'd1, 4'b1000, 5'd7, 1, 0, 0)));
      vecs.push_back(mk("and_f7",   32'h4020F233, 32'd3,      32'd4,      pk(32'd0, 32'd0, 4'b0010, 5'd0, 0, 0, 1)));
      vecs.push_back(mk("lw_neg",   32'hFFC0A403, 32'd100,    32'd8,      pk(32'd100, 32'hFFFFFFFC, 4'b0010, 5'd8, 1, 0, 0)));
      vecs.push_back(mk("sw_pos",   32'h0020AA23, 32'd200,    32'd77,     pk(32'd200, 32'd20, 4'b0010, 5'd0, 0, 0, 0)));
      vecs.push_back(mk("sw_neg",   32'hFE20AC23, 32'd200,    32'd77,     pk(32'd200, 32'hFFFFFFF8, 4'b0010, 5'd0, 0, 0, 0)));
      vecs.push_back(mk("ori_max",  32'h7FF0E493, 32'hA0,     32'd0,      pk(32'hA0, 32'h7FF, 4'b0001, 5'd9, 1, 0, 0)));
      vecs.push_back(mk("slli_ill", 32'h00109093, 32'd6,      32'd6,      pk(32'd0, 32'd0, 4'b0010, 5'd0, 0, 0, 1)));
      vecs.push_back(mk("lb_ill",   32'h00008083, 32'd6,      32'd6,      pk(32'd0, 32'd0, 4'b0010, 5'd0, 0, 0, 1)));
      vecs.push_back(mk("bne_ill",  32'h00209463, 32'd6,      32'd6,      pk(32'd0, 32'd0, 4'b0010, 5'd0, 0, 0, 1)));
      vecs.push_back(mk("sub_x0",   32'h40208033, 32'd9,      32'd4,      pk(32'd9, 32'd4, 4'b0100, 5'd0, 0, 0, 0)));

      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 32'd0, 32'd0, 32'd0);
      #12;
      chk_bit("reset out_valid", out_valid, 1'b0);
      chk_pay("reset payload", dut_pay, '0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      chk_bit("post-reset in_ready", in_ready, 1'b1);
      chk_bit("post-reset out_valid", out_valid, 1'b0);

      // Directed decode table, streamed back to back
      out_ready = 1'b1;
      foreach (vecs[i]) begin
         drive(1'b1, vecs[i].instr, vecs[i].rs1, vecs[i].rs2);
         @(negedge clk);
         chk_bit({vecs[i].name, " valid"}, out_valid, 1'b1);
         chk_pay(vecs[i].name, dut_pay, vecs[i].exp);
      end
      drive(1'b0, 32'd0, 32'd0, 32'd0);
      @(negedge clk);
      chk_bit("table drained", out_valid, 1'b0);

      // Backpressure: A in M, B in S, C held upstream, then in-order drain
      pa = ref_decode(32'h002081B3, 32'd23, 32'd42);
      pb = ref_decode(32'h40208133, 32'd42, 32'd23);
      pc = ref_decode(32'hFFF00293, 32'd0, 32'd1);
      out_ready = 1'b0;
      drive(1'b1, 32'h002081B3, 32'd23, 32'd42);
      @(negedge clk);
      chk_bit("bp A in_ready", in_ready, 1'b1);
      chk_pay("bp A held", dut_pay, pa);
      drive(1'b1, 32'h40208133, 32'd42, 32'd23);
      @(negedge clk);
      chk_bit("bp S full in_ready", in_ready, 1'b0);
      chk_pay("bp A stable", dut_pay, pa);
      drive(1'b1, 32'hFFF00293, 32'd0, 32'd1);
      @(negedge clk);
      chk_bit("bp C blocked", in_ready, 1'b0);
      chk_pay("bp A still", dut_pay, pa);
      out_ready = 1'b1;
      @(negedge clk);
      chk_pay("bp B out", dut_pay, pb);
      chk_bit("bp in_ready back", in_ready, 1'b1);
      @(negedge clk);
      chk_pay("bp C out", dut_pay, pc);
      drive(1'b0, 32'd0, 32'd0, 32'd0);
      @(negedge clk);
      chk_bit("bp drained", out_valid, 1'b0);

      // Flush with both entries full
      out_ready = 1'b0;
      drive(1'b1, 32'h002081B3, 32'd1, 32'd2);
      @(negedge clk);
      drive(1'b1, 32'h40208133, 32'd3, 32'd4);
      @(negedge clk);
      drive(1'b0, 32'd0, 32'd0, 32'd0);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk_bit("flush out_valid", out_valid, 1'b0);
      chk_bit("flush in_ready", in_ready, 1'b1);
      // Flush while a bundle is accepted in the same cycle
      drive(1'b1, 32'h0020F233, 32'd5, 32'd6);
      @(negedge clk);
      drive(1'b1, 32'h0020E333, 32'd7, 32'd8);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      drive(1'b0, 32'd0, 32'd0, 32'd0);
      out_ready = 1'b1;
      chk_bit("flush drops accepted", out_valid, 1'b0);
      @(negedge clk);
      chk_bit("flush nothing later", out_valid, 1'b0);

      // Illegal word, then asynchronous reset in the middle of a stall
      out_ready = 1'b0;
      drive(1'b1, 32'h00000000, 32'hDEAD, 32'hBEEF);
      @(negedge clk);
      chk_pay("illegal stalled", dut_pay, pk(32'd0, 32'd0, 4'b0010, 5'd0, 0, 0, 1));
      drive(1'b1, 32'h002081B3, 32'd1, 32'd1);
      @(negedge clk);
      drive(1'b0, 32'd0, 32'd0, 32'd0);
      chk_bit("stall full", in_ready, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk_bit("async reset out_valid", out_valid, 1'b0);
      chk_bit("async reset in_ready", in_ready, 1'b1);
      chk_pay("async reset payload", dut_pay, '0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      chk_bit("after reset empty", out_valid, 1'b0);

      // Random traffic against a two-deep FIFO model
      exp_q.delete();
      for (int c = 0; c < 3000; c++) begin
         chk_bit("rnd out_valid", out_valid, exp_q.size() > 0);
         chk_bit("rnd in_ready", in_ready, exp_q.size() < 2);
         if (exp_q.size() > 0) chk_pay("rnd payload", dut_pay, exp_q[0]);
         drive($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom);
         out_ready = $urandom_range(0, 2) != 0;
         flush     = $urandom_range(0, 24) == 0;
         acc  = in_valid && (exp_q.size() < 2);
         xfer = out_ready && (exp_q.size() > 0);
         if (flush) exp_q.delete();
         else begin
            if (xfer) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(ref_decode(in_instr, in_rs1_data, in_rs2_data));
         end
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ex_operand_issue.md
Name: ex_operand_issue

Overview:
- Registered ID/EX issue stage directly upstream of the ALU.
- Accepts a decoded-stage bundle: the RV32I instruction word plus rs1/rs2 values read from the register file.
- Produces the ALU operands in1/in2, the 4-bit alu_control code and writeback sideband.
- Uses a valid/ready handshake with a 2-entry skid buffer so the stage holds full throughput under backpressure.

Parameters:
- XLEN, 32, datapath width of operands and immediates.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous kill of all held entries
- in_valid  input  1  upstream bundle valid
- in_ready  output  1  stage can accept a bundle this cycle
- in_instr  input  32  RV32I instruction word
- in_rs1_data  input  XLEN  rs1 register value
- in_rs2_data  input  XLEN  rs2 register value
- out_valid  output  1  issued bundle valid to ALU
- out_ready  input  1  ALU/EX consumer accepts bundle
- out_in1  output  XLEN  ALU operand 1
- out_in2  output  XLEN  ALU operand 2
- out_alu_control  output  4  ALU operation code
- out_rd  output  5  destination register
- out_reg_write  output  1  writeback enable
- out_is_branch  output  1  BEQ; consumer tests zero_flag
- out_illegal  output  1  unsupported encoding

Behaviour:
- Reset: asynchronous on rst_n low. All outputs go to 0 immediately and the skid entry is cleared. in_ready is 1 after reset release.
- alu_control encoding: 0000 AND, 0001 OR, 0010 ADD, 0100 SUB, 1000 SLT (signed).
- Decode, R-type opcode 0110011:
  - funct3 000 with funct7 0000000 -> ADD; with funct7 0100000 -> SUB.
  - funct3 111 -> AND, 110 -> OR, 010 -> SLT; these require funct7 = 0.
  - in2 = rs2.
- Decode, I-ALU opcode 0010011: funct3 000/111/110/010 -> ADD/AND/OR/SLT. in2 = sign-extended instr[31:20].
- Decode, load opcode 0000011, funct3 010: ADD, in2 = I-immediate, reg_write = 1.
- Decode, store opcode 0100011, funct3 010: ADD, in2 = sign-extended {instr[31:25], instr[11:7]}, reg_write = 0, rd = 0.
- Decode, BEQ opcode 1100011, funct3 000: SUB, in2 = rs2, is_branch = 1, reg_write = 0, rd = 0.
- Common decode rules:
  - in1 = rs1 for every legal instruction.
  - reg_write is forced to 0 when rd = 0.
- Illegal encodings (anything else):
  - illegal = 1, alu_control = 0010, in1 = in2 = 0, reg_write = 0, rd = 0, is_branch = 0.
  - The bundle still issues, so downstream can trap.
- Storage: main register M drives the outputs; skid register S holds one overflow entry.
- Handshake rules:
  - out_valid = M.valid.
  - in_ready = !S.valid (registered, no combinational path from out_ready).
  - Accept = in_valid && in_ready. Transfer = out_valid && out_ready.
- Per-edge update, highest priority first:
  - flush: M.valid = 0 and S.valid = 0. Any bundle accepted in the same cycle is discarded.
  - !M.valid || out_ready: M = S if S.valid, else the decoded input if accepted, else invalid. S.valid = 0.
  - Otherwise (stalled): if accepted, S = the decoded input.
- Latency and throughput: 1 cycle from accept to out_valid when not stalled; 1 bundle per cycle sustained.
- Ordering is strict FIFO. No bundle is lost or duplicated.
- Payload stability: payload is held stable while out_valid && !out_ready. When out_valid = 0 the payload is don't-care but must not be X.
- Reset asserted mid-stall: both entries are dropped and out_valid drops asynchronously.

Test Plan:
1. ADD x3,x1,x2 (0x002081B3), rs1 = 23, rs2 = 42, out_ready = 1 -> next edge: out_valid = 1, in1 = 23, in2 = 42, alu_control = 0010, rd = 3, reg_write = 1.
2. SUB x2,x1,x2 (0x40208133), rs1 = 42, rs2 = 23 -> alu_control = 0100, in1 = 42, in2 = 23. BEQ (0x00208463) -> alu_control = 0100, is_branch = 1, reg_write = 0.
3. ADDI x5,x0,-1 (0xFFF00293), rs1 = 0 -> in2 = 0xFFFFFFFF, alu_control = 0010, rd = 5. ADDI x0,x0,0 (0x00000013) -> reg_write = 0.
4. Backpressure, out_ready = 0 with three back-to-back bundles A, B, C:
   - A lands in M, B in S.
   - in_ready = 0 the cycle after B is accepted; C is held upstream.
   - Raise out_ready -> A, B, C emerge on consecutive cycles, in order.
5. Flush with M and S both full -> next edge out_valid = 0, in_ready = 1. A bundle presented in the flush cycle never appears at the output.
6. Illegal word 0x00000000 -> out_illegal = 1, reg_write = 0, in1 = in2 = 0. Drive rst_n low mid-stall -> out_valid = 0 immediately, without waiting for a clock edge.
